pe_result_arbiter: RTL and testbench
====================================

# pe_result_arbiter

Round-robin arbiter and output stage for the PE's shared 32-bit result path. Three requesters (ALU writeback, load unit, CGRA neighbour link) compete for one output; the block picks a winner, drives the 2-bit select of the PE's 3:1 result mux, and registers the winning word. The registered word is held behind a valid/ready handshake toward the register-file write port / CGRA output link.

## Interface
Parameters:
- DW, 32, data width of each input and of data_out
- NREQ, 3, number of requesters; fixed at 3 because sel is 2 bits

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req  in  3  request per source; bit0 = in_1, bit1 = in_2, bit2 = in_3
- in_1  in  DW  data of source 0
- in_2  in  DW  data of source 1
- in_3  in  DW  data of source 2
- gnt  out  3  one-hot, one-cycle pulse; source i's word was captured this cycle
- sel  out  2  mux select of the held word: 00 = in_1, 01 = in_2, 10 = in_3; 11 never driven
- out_valid  out  1  data_out holds an unconsumed word
- out_ready  in  1  consumer accepts data_out when out_valid & out_ready
- data_out  out  DW  registered winning word
- busy  out  1  out_valid & ~out_ready (stall indicator to the PE pipeline)

## Operation
- Two states:
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1.
- Slot is free in a cycle when the state is EMPTY, or when the state is FULL and out_ready = 1.
- When the slot is free and req != 0:
  - Pick a winner w by rotating priority starting at ptr.
  - Combinationally assert gnt[w].
  - On the clock edge: data_out <= in_(w+1), sel <= w, state <= FULL.
  - Update ptr <= (w == 2) ? 0 : w + 1.
- Slot free and req == 0:
  - FULL with out_ready = 1 → EMPTY.
  - data_out and sel keep their last values.
- FULL and out_ready = 0: hold everything; gnt = 0.
- Requesters keep req high until they see gnt. A req that drops before gnt is simply lost; no error is raised.
- gnt is only asserted when a capture happens; at most one bit is high.
- Rotation order from ptr: ptr, ptr+1, ptr+2 (mod 3). ptr only takes the values 0, 1, 2.

## Timing
- Reset values: state EMPTY, ptr 0, out_valid 0, gnt 000, sel 00, data_out 0, busy 0.
- Reset is asynchronous: asserting rst mid-transfer drops out_valid immediately and discards the held word.
- gnt is combinational from req, state, out_ready and ptr. Inputs are sampled in the same cycle as gnt.
- Latency: req asserted in cycle N with the slot free → gnt in cycle N, out_valid and data_out in cycle N+1.
- Throughput: one word per cycle while out_ready = 1. An accept and a new capture in the same cycle keep out_valid = 1 with no bubble.
- No combinational path from req or in_* to out_valid, data_out or sel.
- Simultaneous requests: exactly one wins per cycle. The losers are served within 2 further captures (fairness bound).

## Configuration
- PE_ARB_FIXED_PRI_EN:
  - Defined: fixed priority in_1 > in_2 > in_3. ptr is removed, and sel/gnt follow the lowest set req bit.
  - Undefined (default): round-robin as described above.
- All handshake and timing rules are identical in both builds.

## Test plan
- Reset: hold rst=1 with req=111 → out_valid=0, gnt=000, sel=00, data_out=0. Release rst → first grant gnt=001.
- Single source: req=010, in_2=0xDEADBEEF, out_ready=1 → gnt=010 in cycle N; cycle N+1 out_valid=1, sel=01, data_out=0xDEADBEEF.
- Round-robin: req=111 held, out_ready=1 for 6 cycles → gnt sequence 001,010,100,001,010,100, matched by data_out of in_1, in_2, in_3. With PE_ARB_FIXED_PRI_EN defined → 001 every cycle.
- Backpressure: capture in_3=0x12345678, then out_ready=0 for 4 cycles with req=011 → data_out stable, busy=1, gnt=000. The cycle out_ready=1 → gnt=001 and the next data_out = in_1.
- Drain: FULL, req=000, out_ready=1 → next cycle out_valid=0, data_out unchanged.
- Async reset mid-hold: FULL with out_ready=0, pulse rst between clock edges → out_valid=0 before the next edge; ptr back to 0, so the next grant with req=110 is gnt=010.

Source files
------------

// File: rtl/pe_result_arbiter_if.sv
// Result-path bundle between the three requesters, the arbiter and the consumer.
// slave = arbiter side, master = requesters plus consumer side.
interface pe_result_arbiter_if #(
  parameter int DW = 32
);
  logic [2:0]    req;
  logic [DW-1:0] in_1;
  logic [DW-1:0] in_2;
  logic [DW-1:0] in_3;
  logic [2:0]    gnt;
  logic [1:0]    sel;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] data_out;
  logic          busy;

  modport master (
    output req, in_1, in_2, in_3, out_ready,
    input  gnt, sel, out_valid, data_out, busy
  );

  modport slave (
    input  req, in_1, in_2, in_3, out_ready,
    output gnt, sel, out_valid, data_out, busy
  );
endinterface

// File: rtl/pe_result_arbiter.sv
// 3-way round-robin result arbiter (fixed priority with PE_ARB_FIXED_PRI_EN); gnt same cycle, word registered 1 cycle later.
// One-entry output slot behind valid/ready: out_ready=0 on a full slot freezes everything and suppresses gnt.
module pe_result_arbiter #(
  parameter int DW   = 32,
  parameter int NREQ = 3
) (
  input  logic                clk,
  input  logic                rst,
  pe_result_arbiter_if.slave  bus
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   data_q, data_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      win;
  logic            slot_free;
  logic            cap;
  logic [NREQ-1:0] gnt_c;

`ifndef PE_ARB_FIXED_PRI_EN
  logic [1:0] ptr_q, ptr_d;

  // Search order ptr, ptr+1, ptr+2 (mod 3); ptr never holds 3.
  always_comb begin
    win = 2'd0;
    case (ptr_q)
      2'd1:    win = bus.req[1] ? 2'd1 : (bus.req[2] ? 2'd2 : 2'd0);
      2'd2:    win = bus.req[2] ? 2'd2 : (bus.req[0] ? 2'd0 : 2'd1);
      default: win = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
    endcase
  end
`else
  always_comb begin
    win = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
  end
`endif

  always_comb begin
    slot_free = (state_q == EMPTY) || bus.out_ready;
    // No grant while reset is held: nothing would be captured.
    cap       = slot_free && (bus.req != 3'b000) && !rst;
    state_d   = state_q;
    data_d    = data_q;
    sel_d     = sel_q;
`ifndef PE_ARB_FIXED_PRI_EN
    ptr_d     = ptr_q;
`endif
    if (cap) begin
      state_d = FULL;
      sel_d   = win;
      case (win)
        2'd0:    data_d = bus.in_1;
        2'd1:    data_d = bus.in_2;
        default: data_d = bus.in_3;
      endcase
`ifndef PE_ARB_FIXED_PRI_EN
      ptr_d = (win == 2'd2) ? 2'd0 : win + 2'd1;
`endif
    end else if (slot_free) begin
      state_d = EMPTY;
    end
  end

  assign gnt_c = cap ? (NREQ'(1) << win) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= 2'd0;
`ifndef PE_ARB_FIXED_PRI_EN
      ptr_q   <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
`ifndef PE_ARB_FIXED_PRI_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.sel       = sel_q;
  assign bus.out_valid = (state_q == FULL);
  assign bus.data_out  = data_q;
  assign bus.busy      = (state_q == FULL) && !bus.out_ready;
endmodule

// File: tb/tb_pe_result_arbiter.sv
// Bench for pe_result_arbiter: directed vector table, async-reset sequence, then random traffic vs a queue-level model.
module tb_pe_result_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_result_arbiter_if #(.DW(32)) bus ();
  pe_result_arbiter #(.DW(32), .NREQ(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  req;
    logic [31:0] i1, i2, i3;
    logic        rdy;
    logic [2:0]  gnt;
    logic        vld;
    logic [31:0] dat;
    logic [1:0]  sel;
    logic        busy;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive at negedge, check combinational gnt/busy before the edge, registered outputs after it.
  task automatic step(input logic [2:0] r, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic rdy, input logic [2:0] eg,
                      input logic ev, input logic [31:0] ed, input logic [1:0] es,
                      input logic eb, input string nm);
    @(negedge clk);
    bus.req = r; bus.in_1 = a; bus.in_2 = b; bus.in_3 = c; bus.out_ready = rdy;
    #1;
    chk({nm, ".gnt"}, 32'(bus.gnt), 32'(eg));
    chk({nm, ".busy"}, 32'(bus.busy), 32'(eb));
    @(posedge clk);
    #1;
    chk({nm, ".out_valid"}, 32'(bus.out_valid), 32'(ev));
    chk({nm, ".data_out"}, bus.data_out, ed);
    chk({nm, ".sel"}, 32'(bus.sel), 32'(es));
  endtask

  function automatic int pick(input logic [2:0] r, input int p);
    for (int k = 0; k < 3; k++) if (r[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction

  // Reference model state
  logic        mvld;
  logic [31:0] mdat;
  logic [1:0]  msel;
  int          mptr;
  logic        pend[3];
  logic [31:0] pdat[3];
  int          waitc[3];

  initial begin
    // Round-robin sweep with all three requesting
    for (int i = 0; i < 6; i++) begin
      int w;
`ifdef PE_ARB_FIXED_PRI_EN
      w = 0;
`else
      w = i % 3;
`endif
      tbl[i].req  = 3'b111;
      tbl[i].i1   = 32'h1000_0000 + i;
      tbl[i].i2   = 32'h2000_0000 + i;
      tbl[i].i3   = 32'h3000_0000 + i;
      tbl[i].rdy  = 1'b1;
      tbl[i].gnt  = 3'b001 << w;
      tbl[i].vld  = 1'b1;
      tbl[i].dat  = (w == 0) ? tbl[i].i1 : (w == 1) ? tbl[i].i2 : tbl[i].i3;
      tbl[i].sel  = 2'(w);
      tbl[i].busy = 1'b0;
    end
    tbl[6]  = '{3'b010, 32'h0, 32'hDEADBEEF, 32'h0, 1'b1, 3'b010, 1'b1, 32'hDEADBEEF, 2'd1, 1'b0};
    tbl[7]  = '{3'b100, 32'h0, 32'h0, 32'h12345678, 1'b1, 3'b100, 1'b1, 32'h12345678, 2'd2, 1'b0};
    for (int i = 8; i < 12; i++)
      tbl[i] = '{3'b011, 32'hAAAA0001, 32'hBBBB0002, 32'h0, 1'b0, 3'b000, 1'b1, 32'h12345678, 2'd2, 1'b1};
    tbl[12] = '{3'b011, 32'hAAAA0001, 32'hBBBB0002, 32'h0, 1'b1, 3'b001, 1'b1, 32'hAAAA0001, 2'd0, 1'b0};
    tbl[13] = '{3'b000, 32'h0, 32'h0, 32'h0, 1'b1, 3'b000, 1'b0, 32'hAAAA0001, 2'd0, 1'b0};

    // Reset held with all requests up
    rst = 1'b1;
    bus.req = 3'b111; bus.in_1 = 32'h11; bus.in_2 = 32'h22; bus.in_3 = 32'h33; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.gnt", 32'(bus.gnt), 32'h0);
    chk("rst.out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst.sel", 32'(bus.sel), 32'h0);
    chk("rst.data_out", bus.data_out, 32'h0);
    chk("rst.busy", 32'(bus.busy), 32'h0);
    bus.req = 3'b000;
    rst = 1'b0;

    for (int i = 0; i < 14; i++)
      step(tbl[i].req, tbl[i].i1, tbl[i].i2, tbl[i].i3, tbl[i].rdy, tbl[i].gnt,
           tbl[i].vld, tbl[i].dat, tbl[i].sel, tbl[i].busy, $sformatf("vec%0d", i));

    // Async reset while a word is stalled; in_2 win leaves ptr at 2 beforehand
    step(3'b010, 32'h0, 32'h55550002, 32'h0, 1'b1, 3'b010, 1'b1, 32'h55550002, 2'd1, 1'b0, "ar.cap");
    step(3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 3'b000, 1'b1, 32'h55550002, 2'd1, 1'b1, "ar.hold");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar.out_valid", 32'(bus.out_valid), 32'h0);
    chk("ar.data_out", bus.data_out, 32'h0);
    chk("ar.busy", 32'(bus.busy), 32'h0);
    #1 rst = 1'b0;
    step(3'b110, 32'h0, 32'h66660002, 32'h77770003, 1'b0, 3'b010, 1'b1, 32'h66660002, 2'd1, 1'b0, "ar.next");

    // Random traffic: requesters hold req until granted
    @(negedge clk);
    bus.req = 3'b000;
    rst = 1'b1;
    #2 rst = 1'b0;
    mvld = 1'b0; mdat = 32'h0; msel = 2'd0; mptr = 0;
    for (int i = 0; i < 3; i++) begin pend[i] = 1'b0; pdat[i] = 32'h0; waitc[i] = 0; end
    for (int n = 0; n < 300; n++) begin
      logic [2:0] r;
      logic [2:0] eg;
      logic       rdy, free, eb;
      int         w;
      for (int i = 0; i < 3; i++)
        if (!pend[i] && $urandom_range(2) == 0) begin pend[i] = 1'b1; pdat[i] = $urandom; end
      r    = {pend[2], pend[1], pend[0]};
      rdy  = ($urandom_range(3) != 0);
      eb   = mvld && !rdy;
      free = !mvld || rdy;
      eg   = 3'b000;
      if (free && r != 3'b000) begin
        w    = pick(r, mptr);
        eg   = 3'b001 << w;
        mvld = 1'b1;
        mdat = pdat[w];
        msel = 2'(w);
`ifndef PE_ARB_FIXED_PRI_EN
        mptr = (w + 1) % 3;
        checks++;
        if (waitc[w] > 2) begin
          errors++;
          $display("FAIL fairness: source %0d waited %0d captures, limit 2", w, waitc[w]);
        end
        for (int j = 0; j < 3; j++) if (j != w && pend[j]) waitc[j]++;
        waitc[w] = 0;
`endif
        pend[w] = 1'b0;
      end else if (free) begin
        mvld = 1'b0;
      end
      step(r, pdat[0], pdat[1], pdat[2], rdy, eg, mvld, mdat, msel, eb, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
